display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//   Sequences the address/view selection for the register-file/memory display path.
//   Turns board buttons and an auto-scan switch into the ShowMem and Addr inputs of the display block.
//   Supports manual stepping (next/prev), reg/mem view toggle and timed auto-scan.
//   Sits between board I/O and the display block; all outputs are registered.
// PARAMETERS
//   DB_CYCLES  1_000_000   consecutive stable samples needed before a button's filtered level changes
//   AUTO_DIV   50_000_000  clk cycles per auto-scan step (>=2)
//   CNT_W      26          prescaler/debounce counter width; must hold max(DB_CYCLES, AUTO_DIV)
// PORTS
//   clk         in   1  system clock; everything is on its rising edge
//   clr         in   1  asynchronous reset, active-low
//   btn_next    in   1  raw button: step address forward
//   btn_prev    in   1  raw button: step address backward
//   btn_mode    in   1  raw button: toggle register/memory view
//   auto_en     in   1  raw switch: 1 = auto-scan enabled
//   ShowMem     out  1  0 = register view, 1 = memory view
//   Addr        out  6  display address; Addr[5] is always 0 in register view
//   step_pulse  out  1  one-cycle pulse on each auto-scan advance
// BEHAVIOUR
//   Reset (clr=0, async): ShowMem=0, Addr=0, step_pulse=0, state MANUAL, prescaler=0,
//     sync FFs, debounce counters and filtered levels = 0. Takes effect mid-operation with no clock edge.
//   Input path, per input: 2-FF synchronizer, then debounce counter.
//     Counter clears when the synced sample equals the filtered level.
//     Filtered level takes the sample after DB_CYCLES consecutive differing samples.
//   Press = rising edge of filtered level (1-cycle pulse). auto_en is used as its filtered level.
//   Press-pulse cycle N -> new Addr/ShowMem visible in cycle N+1.
//   States: MANUAL (auto_en_f=0) and AUTO (auto_en_f=1).
//     Transition is on filtered auto_en only. Entering or leaving AUTO clears the prescaler.
//   Address update priority, one action per cycle:
//     1. mode press: ShowMem <= ~ShowMem, Addr <= 0, prescaler <= 0.
//     2. next and prev pressed in the same cycle: no change.
//     3. next press: Addr+1; wraps 31->0 in reg view, 63->0 in mem view; prescaler <= 0.
//     4. prev press: Addr-1; wraps 0->31 in reg view, 0->63 in mem view; prescaler <= 0.
//     5. AUTO and prescaler==AUTO_DIV-1: prescaler <= 0, Addr+1 with the wrap rule above, step_pulse=1.
//     6. AUTO otherwise: prescaler+1.
//   Manual presses are honoured in AUTO; a press always restarts the auto interval.
//   step_pulse is asserted only for case 5 and is 0 in every other cycle.
//   In MANUAL the prescaler holds at 0.
//   Addr arithmetic is 6-bit modulo the view size; Addr[5] is forced 0 when ShowMem=0.
// TESTING (bench params DB_CYCLES=4, AUTO_DIV=8)
//   Reset: clr=0 for 3 cycles with buttons toggling -> ShowMem=0, Addr=0, step_pulse=0;
//     outputs clear asynchronously.
//   Reg wrap: drive Addr to 31, hold btn_next 10 cycles -> Addr=0 exactly once;
//     then btn_prev press -> Addr=31.
//   Mode: btn_mode press at Addr=5 -> ShowMem=1, Addr=0; btn_prev press -> Addr=63;
//     btn_next press -> Addr=0.
//   Bounce: btn_next toggles every 2 cycles for 20 cycles, then stays 0 -> Addr unchanged,
//     no press detected.
//   Auto: auto_en=1 stable in mem view from Addr=62 -> Addr 63 then 0, 8 cycles apart,
//     step_pulse 1 cycle each. btn_next press mid-interval -> Addr+1 and next auto step 8 cycles later.
//   Async reset mid-AUTO: clr=0 -> immediately ShowMem=0, Addr=0, state MANUAL.
//     After release with auto_en=1, auto-scan resumes only after 2 + DB_CYCLES cycles.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: button and auto-scan sequencer for the reg/mem display path.
// Debounced presses and a timed prescaler drive registered ShowMem/Addr.
module display_scan_ctrl #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int AUTO_DIV  = 50_000_000,
    parameter int CNT_W     = 26
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_mode,
    input  logic       auto_en,
    output logic       ShowMem,
    output logic [5:0] Addr,
    output logic       step_pulse
);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(AUTO_DIV - 1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [2:0]       filt;
    logic [2:0]       filt_d;
    logic [2:0]       press;
    logic [CNT_W-1:0] db_cnt [3];

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] auto_cnt;
    logic [CNT_W-1:0] auto_cnt_n;

    logic [CNT_W-1:0] presc;
    logic [CNT_W-1:0] presc_n;
    logic             sm_n;
    logic [5:0]       addr_n;
    logic [5:0]       addr_inc;
    logic [5:0]       addr_dec;
    logic             step_n;

    // bit order: 0 next, 1 prev, 2 mode, 3 auto_en
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {auto_en, btn_mode, btn_prev, btn_next};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
            filt   <= '0;
            filt_d <= '0;
        end else begin
            filt_d <= filt;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    filt[i]   <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = filt & ~filt_d;

    // The auto_en debouncer's filtered level is the scan state itself
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= MANUAL;
            auto_cnt <= '0;
        end else begin
            state    <= state_n;
            auto_cnt <= auto_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        auto_cnt_n = '0;
        if (sync2[3] != (state == AUTO)) begin
            if (auto_cnt == DB_LAST) begin
                state_n = (state == AUTO) ? MANUAL : AUTO;
            end else begin
                auto_cnt_n = auto_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        addr_inc = Addr + 6'd1;
        addr_dec = Addr - 6'd1;
        if (!ShowMem) begin
            addr_inc[5] = 1'b0;
            addr_dec[5] = 1'b0;
        end
        sm_n    = ShowMem;
        addr_n  = Addr;
        presc_n = presc;
        step_n  = 1'b0;
        if (press[2]) begin
            sm_n    = ~ShowMem;
            addr_n  = '0;
            presc_n = '0;
        end else if (press[0] && press[1]) begin
            presc_n = presc;
        end else if (press[0]) begin
            addr_n  = addr_inc;
            presc_n = '0;
        end else if (press[1]) begin
            addr_n  = addr_dec;
            presc_n = '0;
        end else if (state == AUTO && presc == DIV_LAST) begin
            addr_n  = addr_inc;
            presc_n = '0;
            step_n  = 1'b1;
        end else if (state == AUTO) begin
            presc_n = presc + 1'b1;
        end else begin
            presc_n = '0;
        end
        // every change of scan state starts a fresh interval
        if (state != state_n) presc_n = '0;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ShowMem    <= 1'b0;
            Addr       <= '0;
            presc      <= '0;
            step_pulse <= 1'b0;
        end else begin
            ShowMem    <= sm_n;
            Addr       <= addr_n;
            presc      <= presc_n;
            step_pulse <= step_n;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed table, corner sequences and random stimulus
// checked against a window-based reference model of the scan controller.
module tb_display_scan_ctrl;

    localparam int DB  = 4;
    localparam int DIV = 8;

    logic       clk;
    logic       clr;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_mode;
    logic       auto_en;
    logic       ShowMem;
    logic [5:0] Addr;
    logic       step_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b1;

    display_scan_ctrl #(
        .DB_CYCLES(DB),
        .AUTO_DIV (DIV),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .btn_next  (btn_next),
        .btn_prev  (btn_prev),
        .btn_mode  (btn_mode),
        .auto_en   (auto_en),
        .ShowMem   (ShowMem),
        .Addr      (Addr),
        .step_pulse(step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: raw inputs reach the filter two samples late; a
    // filtered level flips once the last DB samples all disagree with it.
    bit [3:0] syncq[$];
    bit       win[4][$];
    bit [3:0] mfilt;
    bit [3:0] mpress;
    bit       msm;
    int       maddr;
    int       mpre;
    bit       mstep;

    task automatic m_reset();
        syncq = {4'b0, 4'b0};
        for (int i = 0; i < 4; i++) win[i].delete();
        mfilt  = '0;
        mpress = '0;
        msm    = 1'b0;
        maddr  = 0;
        mpre   = 0;
        mstep  = 1'b0;
    endtask

    task automatic m_step(input bit [3:0] raw);
        bit [3:0] s;
        bit [3:0] fo;
        bit       all;
        int       size;
        s = syncq.pop_front();
        syncq.push_back(raw);
        fo = mfilt;
        for (int i = 0; i < 4; i++) begin
            win[i].push_back(s[i]);
            if (win[i].size() > DB) void'(win[i].pop_front());
            if (win[i].size() == DB) begin
                all = 1'b1;
                foreach (win[i][j]) if (win[i][j] == mfilt[i]) all = 1'b0;
                if (all) begin
                    mfilt[i] = s[i];
                    win[i].delete();
                end
            end
        end
        size  = msm ? 64 : 32;
        mstep = 1'b0;
        if (mpress[2]) begin
            msm   = ~msm;
            maddr = 0;
            mpre  = 0;
        end else if (mpress[0] && mpress[1]) begin
            mpre = mpre;
        end else if (mpress[0]) begin
            maddr = (maddr + 1) % size;
            mpre  = 0;
        end else if (mpress[1]) begin
            maddr = (maddr + size - 1) % size;
            mpre  = 0;
        end else if (fo[3]) begin
            if (mpre == DIV - 1) begin
                mpre  = 0;
                maddr = (maddr + 1) % size;
                mstep = 1'b1;
            end else begin
                mpre++;
            end
        end
        if (!fo[3] || mfilt[3] != fo[3]) mpre = 0;
        mpress = mfilt & ~fo;
    endtask

    always @(posedge clk or negedge clr) begin
        if (!clr) m_reset();
        else m_step({auto_en, btn_mode, btn_prev, btn_next});
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("model_showmem", int'(ShowMem), int'(msm));
            chk("model_addr", int'(Addr), maddr);
            chk("model_step", int'(step_pulse), int'(mstep));
        end
    end

    typedef struct {
        string      name;
        logic [2:0] btn;
        logic       sm;
        logic [5:0] addr;
        int         nchg;
    } vec_t;

    task automatic press_btn(input logic [2:0] b, output int chg);
        logic [5:0] last;
        chg  = 0;
        last = Addr;
        {btn_mode, btn_prev, btn_next} = b;
        repeat (10) begin
            @(negedge clk);
            if (Addr != last) begin chg++; last = Addr; end
        end
        {btn_mode, btn_prev, btn_next} = 3'b000;
        repeat (10) begin
            @(negedge clk);
            if (Addr != last) begin chg++; last = Addr; end
        end
    endtask

    task automatic wait_step(input int bound, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (step_pulse) ok = 1'b1;
        end
    endtask

    vec_t vecs[$];

    initial begin
        int         chg;
        int         cyc;
        bit         ok;
        logic [5:0] a0;
        clr = 1'b0;
        btn_next = 1'b0; btn_prev = 1'b0; btn_mode = 1'b0; auto_en = 1'b0;

        vecs.push_back('{"next_1",    3'b001, 1'b0, 6'd1,  1});
        vecs.push_back('{"next_2",    3'b001, 1'b0, 6'd2,  1});
        vecs.push_back('{"prev_1",    3'b010, 1'b0, 6'd1,  1});
        vecs.push_back('{"prev_0",    3'b010, 1'b0, 6'd0,  1});
        vecs.push_back('{"prev_wr31", 3'b010, 1'b0, 6'd31, 1});
        vecs.push_back('{"next_wr0",  3'b001, 1'b0, 6'd0,  1});
        vecs.push_back('{"both_hold", 3'b011, 1'b0, 6'd0,  0});
        vecs.push_back('{"next_a",    3'b001, 1'b0, 6'd1,  1});
        vecs.push_back('{"next_b",    3'b001, 1'b0, 6'd2,  1});
        vecs.push_back('{"next_c",    3'b001, 1'b0, 6'd3,  1});
        vecs.push_back('{"next_d",    3'b001, 1'b0, 6'd4,  1});
        vecs.push_back('{"next_e",    3'b001, 1'b0, 6'd5,  1});
        vecs.push_back('{"mode_mem",  3'b100, 1'b1, 6'd0,  1});
        vecs.push_back('{"prev_wr63", 3'b010, 1'b1, 6'd63, 1});
        vecs.push_back('{"next_wr0m", 3'b001, 1'b1, 6'd0,  1});
        vecs.push_back('{"prev_63",   3'b010, 1'b1, 6'd63, 1});
        vecs.push_back('{"prev_62",   3'b010, 1'b1, 6'd62, 1});

        // reset held with buttons toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {btn_mode, btn_prev, btn_next} = 3'(i + 5);
            chk("rst_showmem", int'(ShowMem), 0);
            chk("rst_addr", int'(Addr), 0);
            chk("rst_step", int'(step_pulse), 0);
        end
        @(negedge clk);
        {btn_mode, btn_prev, btn_next} = 3'b000;
        clr = 1'b1;
        repeat (12) @(negedge clk);

        foreach (vecs[i]) begin
            press_btn(vecs[i].btn, chg);
            chk({vecs[i].name, "_sm"}, int'(ShowMem), int'(vecs[i].sm));
            chk({vecs[i].name, "_addr"}, int'(Addr), int'(vecs[i].addr));
            chk({vecs[i].name, "_chg"}, chg, vecs[i].nchg);
        end

        // bounce: toggling faster than the debounce window
        a0 = Addr;
        chg = 0;
        btn_next = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_next = ~btn_next;
            repeat (2) begin
                @(negedge clk);
                if (Addr != a0) chg++;
            end
        end
        btn_next = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (Addr != a0) chg++;
        end
        chk("bounce_addr", int'(Addr), 62);
        chk("bounce_nochg", chg, 0);

        // auto-scan in memory view from 62
        auto_en = 1'b1;
        wait_step(40, cyc, ok);
        chk("auto1_seen", int'(ok), 1);
        chk("auto1_addr", int'(Addr), 63);
        wait_step(20, cyc, ok);
        chk("auto2_seen", int'(ok), 1);
        chk("auto2_gap", cyc, DIV);
        chk("auto2_addr", int'(Addr), 0);
        btn_next = 1'b1;
        a0 = Addr;
        cyc = 0;
        while (Addr == a0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        btn_next = 1'b0;
        chk("auto_press_addr", int'(Addr), 1);
        chk("auto_press_nostep", int'(step_pulse), 0);
        wait_step(20, cyc, ok);
        chk("auto3_seen", int'(ok), 1);
        chk("auto3_restart_gap", cyc, DIV);
        chk("auto3_addr", int'(Addr), 2);

        // asynchronous reset in the middle of a cycle
        repeat (3) @(negedge clk);
        #2 clr = 1'b0;
        #1;
        chk("async_showmem", int'(ShowMem), 0);
        chk("async_addr", int'(Addr), 0);
        chk("async_step", int'(step_pulse), 0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        wait_step(40, cyc, ok);
        chk("resume_seen", int'(ok), 1);
        chk("resume_delay", cyc, 2 + DB + DIV);
        chk("resume_addr", int'(Addr), 1);
        chk("resume_showmem", int'(ShowMem), 0);

        // random stimulus, the model monitor does the checking
        for (int k = 0; k < 350; k++) begin
            btn_next = ($urandom_range(0, 3) == 0);
            btn_prev = ($urandom_range(0, 3) == 0);
            btn_mode = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) auto_en = ~auto_en;
            repeat ($urandom_range(1, 14)) @(negedge clk);
            if ($urandom_range(0, 59) == 0) begin
                #2 clr = 1'b0;
                #1 clr = 1'b1;
                @(negedge clk);
            end
        end

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
